// File: rtl/psr_pkg.sv
// Shared types and helpers for the power spectrum accumulator.
// Provides state enums, default widths, clog2 and a saturating add.
package psr_pkg;

    localparam int ACC_W_DEF = 64;
    localparam int PWR_W     = 48;
    // Working width of the saturating adder; covers any ACC_W up to 127.
    localparam int SAT_W     = 128;

    typedef enum logic {
        IN_SEEK,
        IN_ACC
    } in_state_t;

    typedef enum logic {
        D_IDLE,
        D_RUN
    } dump_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // a + b clamped to 2**w-1 (w < SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [PWR_W-1:0] b,
        input int               w
    );
        logic [SAT_W:0]   s;
        logic [SAT_W-1:0] lim;
        s   = {1'b0, a} + {1'b0, SAT_W'(b)};
        lim = (SAT_W'(1) << w) - SAT_W'(1);
        return (s > {1'b0, lim}) ? lim : s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/acc_bank_ram.sv
// One accumulator bank: simple dual-port RAM, one write, one read port.
// Ports: clk; we/waddr/wdata write; raddr in, rdata out one cycle later.
module acc_bank_ram
    import psr_pkg::*;
#(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = ACC_W_DEF,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/power_spectrum_accum.sv
// Integrates per-bin FFT power over ACC_LEN frames in ping-pong banks
// and streams each finished spectrum out on a valid/ready port.
// Ports: clk, rst_n (sync, active-low); en_sync_in/cnt_sync_in/pwr_in
// input stream; dout_valid/ready/bin/data/last output stream;
// integ_cnt, ovf_drop, sync_err status.
module power_spectrum_accum
    import psr_pkg::*;
#(
    parameter int BITWIDTH  = 7,
    parameter int FFT_POINT = 512,
    parameter int ACC_LEN   = 1024,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_sync_in,
    input  logic [BITWIDTH+1:0] cnt_sync_in,
    input  logic [PWR_W-1:0]   pwr_in,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [BITWIDTH+1:0] dout_bin,
    output logic [ACC_W-1:0]   dout_data,
    output logic               dout_last,
    output logic [15:0]        integ_cnt,
    output logic               ovf_drop,
    output logic               sync_err
);

    localparam int BW = BITWIDTH + 2;
    localparam int FW = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
    localparam logic [BW-1:0] LAST_BIN = BW'(FFT_POINT - 1);
    localparam logic [FW-1:0] LAST_FRM = FW'(ACC_LEN - 1);

    // input tracking
    in_state_t     in_st;
    logic [BW-1:0] exp_bin;
    logic [FW-1:0] frame;
    logic          acc_sel;

    logic          hit, restart, take, brk, end_integ;
    logic [FW-1:0] frm_cur;

    // RMW pipeline
    logic             s1_v, s1_first, s1_end, s1_bank;
    logic [BW-1:0]    s1_bin;
    logic [PWR_W-1:0] s1_pwr;
    logic [ACC_W-1:0] s1_sum;
    logic             s2_v, s2_end;
    logic [BW-1:0]    s2_bin;
    logic [ACC_W-1:0] s2_data;

    // banks
    logic [1:0]       we;
    logic [BW-1:0]    raddr [2];
    logic [ACC_W-1:0] rdata [2];

    // dump
    dump_state_t      d_st;
    logic             d_bank;
    logic [BW-1:0]    rd_addr;
    logic             rd_all;
    logic             pend_v;
    logic [BW-1:0]    pend_bin;
    logic             out_v, out_last;
    logic [BW-1:0]    out_bin;
    logic [ACC_W-1:0] out_data;
    logic             sk_v, sk_last;
    logic [BW-1:0]    sk_bin;
    logic [ACC_W-1:0] sk_data;

    logic       pop, fin, busy, swap, drop, issue;
    logic [1:0] keep;

    always_comb begin
        hit       = en_sync_in && (in_st == IN_ACC)
                    && (cnt_sync_in == exp_bin);
        // A bin-0 sample that is not the expected one starts afresh.
        restart   = en_sync_in && !hit && (cnt_sync_in == '0);
        take      = hit || restart;
        brk       = en_sync_in && (in_st == IN_ACC) && !hit;
        frm_cur   = restart ? '0 : frame;
        end_integ = take && (cnt_sync_in == LAST_BIN)
                    && (frm_cur == LAST_FRM);
    end

    // Frame 0 overwrites, so a restarted bank needs no clearing.
    always_comb begin
        s1_sum = s1_first
               ? ACC_W'(s1_pwr)
               : ACC_W'(sat_add(SAT_W'(rdata[s1_bank]), s1_pwr, ACC_W));
    end

    always_comb begin
        pop   = out_v && dout_ready;
        fin   = pop && out_last;
        busy  = (d_st == D_RUN) && !fin;
        swap  = s2_v && s2_end && !busy;
        drop  = s2_v && s2_end && busy;
        // Entries still held after this cycle; a new read may only
        // launch if its data is guaranteed a slot next cycle.
        keep  = {1'b0, pend_v} + {1'b0, out_v}
              + {1'b0, sk_v} - {1'b0, pop};
        issue = (d_st == D_RUN) && !rd_all && (keep <= 2'd1);
    end

    for (genvar k = 0; k < 2; k++) begin : g_bank
        assign we[k]    = s2_v && (acc_sel == 1'(k));
        assign raddr[k] = (acc_sel == 1'(k)) ? cnt_sync_in : rd_addr;

        acc_bank_ram #(
            .DEPTH (FFT_POINT),
            .WIDTH (ACC_W)
        ) u_ram (
            .clk   (clk),
            .we    (we[k]),
            .waddr (s2_bin),
            .wdata (s2_data),
            .raddr (raddr[k]),
            .rdata (rdata[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_st    <= IN_SEEK;
            exp_bin  <= '0;
            frame    <= '0;
            sync_err <= 1'b0;
        end else begin
            if (take) begin
                in_st   <= IN_ACC;
                exp_bin <= cnt_sync_in + 1'b1;
                if (cnt_sync_in == LAST_BIN) begin
                    frame <= (frm_cur == LAST_FRM) ? '0
                                                   : frm_cur + 1'b1;
                end else begin
                    frame <= frm_cur;
                end
            end else if (brk) begin
                in_st <= IN_SEEK;
            end
            if (brk) begin
                sync_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_end   <= 1'b0;
            s1_bank  <= 1'b0;
            s1_bin   <= '0;
            s1_pwr   <= '0;
            s2_v     <= 1'b0;
            s2_end   <= 1'b0;
            s2_bin   <= '0;
            s2_data  <= '0;
        end else begin
            s1_v     <= take;
            s1_first <= (frm_cur == '0);
            s1_end   <= end_integ;
            s1_bank  <= acc_sel;
            s1_bin   <= cnt_sync_in;
            s1_pwr   <= pwr_in;
            s2_v     <= s1_v;
            s2_end   <= s1_v && s1_end;
            s2_bin   <= s1_bin;
            s2_data  <= s1_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_sel   <= 1'b0;
            d_st      <= D_IDLE;
            d_bank    <= 1'b0;
            rd_addr   <= '0;
            rd_all    <= 1'b0;
            integ_cnt <= '0;
            ovf_drop  <= 1'b0;
        end else begin
            if (swap) begin
                acc_sel   <= ~acc_sel;
                d_bank    <= acc_sel;
                d_st      <= D_RUN;
                rd_addr   <= '0;
                rd_all    <= 1'b0;
                integ_cnt <= integ_cnt + 16'd1;
            end else begin
                if (fin) begin
                    d_st <= D_IDLE;
                end
                if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    if (rd_addr == LAST_BIN) begin
                        rd_all <= 1'b1;
                    end
                end
            end
            if (drop) begin
                ovf_drop <= 1'b1;
            end
        end
    end

    // Output register plus one-entry skid absorbing the read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_v   <= 1'b0;
            pend_bin <= '0;
            out_v    <= 1'b0;
            out_bin  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            sk_v     <= 1'b0;
            sk_bin   <= '0;
            sk_data  <= '0;
            sk_last  <= 1'b0;
        end else begin
            pend_v <= issue;
            if (issue) begin
                pend_bin <= rd_addr;
            end
            if (!out_v || pop) begin
                if (sk_v) begin
                    out_v    <= 1'b1;
                    out_bin  <= sk_bin;
                    out_data <= sk_data;
                    out_last <= sk_last;
                    sk_v     <= 1'b0;
                end else if (pend_v) begin
                    out_v    <= 1'b1;
                    out_bin  <= pend_bin;
                    out_data <= rdata[d_bank];
                    out_last <= (pend_bin == LAST_BIN);
                end else begin
                    out_v <= 1'b0;
                end
            end else if (pend_v) begin
                sk_v    <= 1'b1;
                sk_bin  <= pend_bin;
                sk_data <= rdata[d_bank];
                sk_last <= (pend_bin == LAST_BIN);
            end
        end
    end

    assign dout_valid = out_v;
    assign dout_bin   = out_bin;
    assign dout_data  = out_data;
    assign dout_last  = out_last;

endmodule

// File: tb/tb_power_spectrum_accum.sv
// Randomized self-checking bench for power_spectrum_accum.
// Reference model integrates per bin at the stream level.
module tb_power_spectrum_accum;

    localparam int BITWIDTH = 1;
    localparam int NP       = 8;
    localparam int AL       = 4;
    localparam int AW       = 48;
    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  cnt = '0;
    logic [47:0] pwr = '0;
    logic        dout_ready = 1'b0;
    logic        dout_valid;
    logic [2:0]  dout_bin;
    logic [47:0] dout_data;
    logic        dout_last;
    logic [15:0] integ_cnt;
    logic        ovf_drop;
    logic        sync_err;

    power_spectrum_accum #(
        .BITWIDTH  (BITWIDTH),
        .FFT_POINT (NP),
        .ACC_LEN   (AL),
        .ACC_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_sync_in  (en),
        .cnt_sync_in (cnt),
        .pwr_in      (pwr),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_bin    (dout_bin),
        .dout_data   (dout_data),
        .dout_last   (dout_last),
        .integ_cnt   (integ_cnt),
        .ovf_drop    (ovf_drop),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ready driver
    bit rdy_rand = 1'b0;
    bit rdy_val  = 1'b1;
    always @(posedge clk) begin
        #1;
        dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // reference model
    logic [63:0] m_sum [NP];
    bit          m_lock;
    int          m_exp, m_frames, m_integ;
    bit          m_ovf, m_serr;
    logic [2:0]  q_bin [$];
    logic [47:0] q_dat [$];
    int          pushed, rcvd;

    task automatic model_reset();
        m_lock = 0; m_exp = 0; m_frames = 0; m_integ = 0;
        m_ovf = 0; m_serr = 0; pushed = 0; rcvd = 0;
        q_bin.delete(); q_dat.delete();
        foreach (m_sum[i]) m_sum[i] = '0;
    endtask

    task automatic model_sample(input int c, input logic [47:0] p);
        bit ok;
        logic [63:0] s;
        ok = 0;
        if (m_lock && c == m_exp) ok = 1;
        else begin
            if (m_lock) m_serr = 1;
            m_lock = 0;
            if (c == 0) begin
                m_lock = 1; m_frames = 0; ok = 1;
                foreach (m_sum[i]) m_sum[i] = '0;
            end
        end
        if (ok) begin
            s = m_sum[c] + 64'(p);
            m_sum[c] = (s > MAXV) ? MAXV : s;
            m_exp = (c + 1) % NP;
            if (c == NP - 1) begin
                m_frames++;
                if (m_frames == AL) begin
                    if (rcvd < pushed) m_ovf = 1;
                    else begin
                        for (int b = 0; b < NP; b++) begin
                            q_bin.push_back(3'(b));
                            q_dat.push_back(m_sum[b][47:0]);
                        end
                        pushed += NP;
                        m_integ++;
                    end
                    m_frames = 0;
                    foreach (m_sum[i]) m_sum[i] = '0;
                end
            end
        end
    endtask

    // output monitor
    bit          pv = 0;
    logic [47:0] pd;
    logic [2:0]  pb;
    logic        pl;
    logic [2:0]  eb;
    logic [47:0] ed;
    always @(negedge clk) begin
        if (!rst_n) pv = 0;
        else begin
            if (pv) begin
                chk("hold_valid", 64'(dout_valid), 64'd1);
                chk("hold_data", 64'(dout_data), 64'(pd));
                chk("hold_bin", 64'(dout_bin), 64'(pb));
                chk("hold_last", 64'(dout_last), 64'(pl));
            end
            if (dout_valid && dout_ready) begin
                rcvd++;
                if (q_bin.size() > 0) begin
                    eb = q_bin.pop_front();
                    ed = q_dat.pop_front();
                    chk("beat_bin", 64'(dout_bin), 64'(eb));
                    chk("beat_data", 64'(dout_data), 64'(ed));
                    chk("beat_last", 64'(dout_last), 64'(eb == 3'(NP - 1)));
                end
            end
            pv = dout_valid && !dout_ready;
            pd = dout_data; pb = dout_bin; pl = dout_last;
        end
    end

    task automatic wait_drain();
        int b;
        b = 0;
        while (rcvd < pushed && b < 400) begin
            @(posedge clk); #1; en = 0; b++;
        end
        if (rcvd < pushed) chk("drain_timeout", 64'(rcvd), 64'(pushed));
    endtask

    task automatic drive(input bit e, input int c, input logic [47:0] p,
                         input bit allow_drop);
        if (e && !allow_drop && m_lock && c == m_exp && c == NP - 1
            && m_frames == AL - 1) wait_drain();
        @(posedge clk); #1;
        en = e; cnt = 3'(c); pwr = p;
        if (e) model_sample(c, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 1);
    endtask

    // mode 0: bin+1, 1: max, 2: random, 3: random with gaps
    task automatic frames(input int nf, input int mode, input bit ad);
        logic [47:0] p;
        for (int f = 0; f < nf; f++) begin
            for (int b = 0; b < NP; b++) begin
                case (mode)
                    0: p = 48'(b + 1);
                    1: p = MAXV[47:0];
                    default: p = ($urandom_range(0, 7) == 0) ? MAXV[47:0]
                                 : {16'($urandom), 32'($urandom)};
                endcase
                if (mode == 3 && $urandom_range(0, 3) == 0) idle(1);
                drive(1, b, p, ad);
            end
        end
    endtask

    task automatic settle(input string t);
        rdy_rand = 0; rdy_val = 1;
        wait_drain();
        idle(4);
        chk({t, "_beats"}, 64'(rcvd), 64'(pushed));
        chk({t, "_integ_cnt"}, 64'(integ_cnt), 64'(m_integ));
        chk({t, "_ovf_drop"}, 64'(ovf_drop), 64'(m_ovf));
        chk({t, "_sync_err"}, 64'(sync_err), 64'(m_serr));
        chk({t, "_idle_valid"}, 64'(dout_valid), 64'd0);
    endtask

    task automatic do_reset();
        en = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_data", 64'(dout_data), 64'd0);
        chk("rst_bin", 64'(dout_bin), 64'd0);
        chk("rst_last", 64'(dout_last), 64'd0);
        chk("rst_integ", 64'(integ_cnt), 64'd0);
        chk("rst_ovf", 64'(ovf_drop), 64'd0);
        chk("rst_sync", 64'(sync_err), 64'd0);
        model_reset();
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // one integration of bin+1
        frames(4, 0, 0);
        settle("basic");

        // stream opening mid-frame
        do_reset();
        for (int b = 5; b < NP; b++) drive(1, b, 48'd99, 0);
        frames(4, 0, 0);
        settle("midstart");

        // two integrations back to back
        do_reset();
        frames(8, 2, 0);
        settle("b2b");

        // stalled output through the second integration end
        do_reset();
        rdy_val = 0;
        frames(8, 2, 1);
        idle(4);
        rdy_val = 1;
        frames(4, 2, 0);
        settle("ovf");

        // broken bin sequence then clean restart
        do_reset();
        drive(1, 0, 48'd7, 0);
        drive(1, 1, 48'd7, 0);
        drive(1, 3, 48'd7, 0);
        for (int b = 4; b < NP; b++) drive(1, b, 48'd7, 0);
        frames(4, 0, 0);
        settle("syncerr");

        // saturation and random stall / gaps
        do_reset();
        rdy_rand = 1;
        frames(4, 1, 0);
        frames(12, 3, 0);
        settle("sat_rand");

        // reset while a dump is stalled
        do_reset();
        rdy_val = 0;
        frames(4, 0, 1);
        idle(6);
        do_reset();
        rdy_val = 1;
        frames(4, 2, 0);
        settle("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
